instruction_store: RTL and testbench
====================================

Name: instruction_store

Overview:
- Parametrised, writable successor to the CPU's fixed combinational instruction ROM.
- Holds the program in an inferred RAM with a registered, one-cycle fetch port.
- A byte-serial loader state machine assembles bytes into instruction words and writes them in sequence, so programs can be replaced at run time without resynthesis.
- Sits between the program counter/fetch stage and an external byte source (UART or switch loader).

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- INSTR_W, 32, instruction width; must be a multiple of 8; BYTES = INSTR_W/8.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  request a read of fetch_addr this cycle.
- fetch_addr  in  ADDR_W  word address to read.
- instruction  out  INSTR_W  fetched word; 0 (NOP) when not valid.
- instr_valid  out  1  one-cycle pulse: instruction is valid.
- busy  out  1  high while the loader is active; fetches are refused.
- load_start  in  1  pulse: begin a load at load_base.
- load_base  in  ADDR_W  first word address of the load.
- load_byte  in  8  incoming program byte, most significant byte of each word first.
- load_strobe  in  1  load_byte is valid this cycle.
- load_stop  in  1  pulse: end the load.
- load_done  out  1  one-cycle pulse when a load ends.
- load_error  out  1  one-cycle pulse, coincident with load_done, if a partial word was discarded.
- load_count  out  ADDR_W+1  words written by the most recent load; held until the next load_start.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset values:
  - instruction = 0, instr_valid = 0, busy = 0, load_done = 0, load_error = 0, load_count = 0, parity_err = 0.
  - State = IDLE; byte counter, shift register and write pointer are cleared.
  - RAM contents are not touched by reset. Power-up contents are all 0 (NOP).
- State IDLE:
  - fetch_req at edge n: instruction = mem[fetch_addr] and instr_valid = 1 after edge n+1, for one cycle.
  - Back-to-back requests give back-to-back valid pulses.
  - Without a request, instr_valid = 0 and instruction = 0.
- IDLE -> LOAD on load_start:
  - ptr <= load_base; byte counter <= 0; load_count <= 0; busy = 1 from the next cycle.
  - load_start has priority over a same-cycle fetch_req. The fetch is dropped and no instr_valid is produced.
- State LOAD:
  - Each load_strobe shifts load_byte into the low byte of the shift register.
  - On the BYTES-th strobe, the assembled word is written to mem[ptr] on that edge. Then ptr increments and load_count increments.
  - ptr wraps from DEPTH-1 to 0. load_count saturates at DEPTH.
  - fetch_req is ignored: instr_valid = 0 and instruction = 0.
  - A further load_start is ignored.
- LOAD -> IDLE on load_stop:
  - load_done pulses one cycle later; busy falls on the same cycle.
  - If the byte counter is nonzero, the partial word is discarded and load_error pulses with load_done.
  - load_strobe and load_stop in the same cycle: the byte is accepted first. If it completes a word, the word is written and there is no error.
- Read-during-write: the RAM cannot be written in IDLE, so there is no collision.
- Reset while in LOAD:
  - Returns to IDLE immediately with no load_done.
  - Words already written are kept; the partial word is lost.
  - load_count is cleared to 0.

Optional Feature:
- Macro: INSTR_STORE_PARITY_EN.
- With the macro defined:
  - Each RAM entry stores an extra even-parity bit computed when the word is written. Power-up entries are 0 with parity 0 (valid).
  - On a fetch, parity is rechecked. On a mismatch, parity_err = 1 coincident with instr_valid, and instruction is forced to 0 (NOP).
- Without the macro:
  - No parity storage.
  - parity_err is tied to 0.

Test Plan:
- Reset, then fetch_req with addr 0x05 -> instr_valid pulses one cycle later with instruction = 0x00000000; busy = 0.
- load_start with base 0x10, then strobe bytes 12 34 56 78 AB CD EF 01, then load_stop -> load_done pulses, load_error = 0, load_count = 2. Fetches from 0x10 and 0x11 return 0x12345678 and 0xABCDEF01, each with 1-cycle latency.
- Load at base 0xFF with 8 bytes -> words are written to 0xFF and 0x00 (wrap), and load_count = 2.
- Load 6 bytes, then load_stop -> load_error pulses with load_done; load_count = 1; the second word's address keeps its old value.
- Same-cycle load_start and fetch_req -> no instr_valid. fetch_req while busy = 1 -> instr_valid stays 0 and instruction = 0.
- Reset asserted mid-load after 5 bytes -> busy = 0 next cycle, no load_done, load_count = 0, and the first word is still readable.

Source files
------------

// File: rtl/instruction_store.sv
// Writable instruction store: inferred RAM with a registered one-cycle fetch port and a byte-serial loader.
// Optional per-word even parity is enabled by defining INSTR_STORE_PARITY_EN.
module instruction_store #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_fetch_req,
    input  logic [ADDR_W-1:0]  i_fetch_addr,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instr_valid,
    output logic               o_busy,
    input  logic               i_load_start,
    input  logic [ADDR_W-1:0]  i_load_base,
    input  logic [7:0]         i_load_byte,
    input  logic               i_load_strobe,
    input  logic               i_load_stop,
    output logic               o_load_done,
    output logic               o_load_error,
    output logic [ADDR_W:0]    o_load_count,
    output logic               o_parity_err
);

    localparam int BYTES = INSTR_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

`ifdef INSTR_STORE_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif

    logic [MEM_W-1:0]   r_mem [DEPTH];
    logic [MEM_W-1:0]   r_rd_word;
    logic               r_valid;

    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [INSTR_W-1:0] r_shift;
    logic [ADDR_W:0]    r_load_count;
    logic               r_load_done;
    logic               r_load_error;

    logic [INSTR_W-1:0] w_shift_next;
    logic [MEM_W-1:0]   w_wr_word;
    logic               w_fetch_ok;
    logic               w_word_done;
    logic               w_we;
    logic [CNT_W-1:0]   w_cnt_after;

    // New byte enters at the bottom, so the first byte of a word ends up most significant.
    generate
        if (INSTR_W == 8) begin : g_shift_byte
            assign w_shift_next = i_load_byte;
        end else begin : g_shift_wide
            assign w_shift_next = {r_shift[INSTR_W-9:0], i_load_byte};
        end
    endgenerate

`ifdef INSTR_STORE_PARITY_EN
    assign w_wr_word = {^w_shift_next, w_shift_next};
`else
    assign w_wr_word = w_shift_next;
`endif

    // A load request wins over a fetch in the same cycle; the fetch is simply dropped.
    assign w_fetch_ok  = i_fetch_req && (r_state == ST_IDLE) && !i_load_start;
    assign w_word_done = (r_state == ST_LOAD) && i_load_strobe && (r_byte_cnt == LAST_BYTE);
    assign w_we        = w_word_done && !i_reset;

    always_comb begin
        w_cnt_after = r_byte_cnt;
        if (i_load_strobe) begin
            w_cnt_after = (r_byte_cnt == LAST_BYTE) ? '0 : (r_byte_cnt + CNT_ONE);
        end
    end

    // RAM port: no reset so the array maps onto block RAM.
    always_ff @(posedge i_clock) begin
        if (w_we) begin
            r_mem[r_ptr] <= w_wr_word;
        end
        if (w_fetch_ok) begin
            r_rd_word <= r_mem[i_fetch_addr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_fetch_ok;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_load_count <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load_start) begin
                        r_state      <= ST_LOAD;
                        r_ptr        <= i_load_base;
                        r_byte_cnt   <= '0;
                        r_shift      <= '0;
                        r_load_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (i_load_strobe) begin
                        r_shift <= w_shift_next;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_ptr      <= r_ptr + PTR_ONE;
                            if (r_load_count != COUNT_MAX) begin
                                r_load_count <= r_load_count + COUNT_ONE;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_ONE;
                        end
                    end
                    // Stop takes effect after any same-cycle byte, so a completing byte is never an error.
                    if (i_load_stop) begin
                        r_state      <= ST_IDLE;
                        r_byte_cnt   <= '0;
                        r_load_done  <= 1'b1;
                        r_load_error <= (w_cnt_after != '0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_STORE_PARITY_EN
    logic w_par_bad;
    assign w_par_bad     = r_valid && (^r_rd_word);
    assign o_parity_err  = w_par_bad;
    assign o_instruction = (r_valid && !w_par_bad) ? r_rd_word[INSTR_W-1:0] : '0;
`else
    assign o_parity_err  = 1'b0;
    assign o_instruction = r_valid ? r_rd_word : '0;
`endif

    assign o_instr_valid = r_valid;
    assign o_busy        = (r_state == ST_LOAD);
    assign o_load_done   = r_load_done;
    assign o_load_error  = r_load_error;
    assign o_load_count  = r_load_count;

endmodule

// File: tb/tb_instruction_store.sv
// Scenario-driven bench for instruction_store: expected fetch words are queued when a fetch is
// issued and compared by a monitor on the falling edge whenever instr_valid is seen.
module tb_instruction_store;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        load_start = 1'b0;
    logic [7:0]  load_base = '0;
    logic [7:0]  load_byte = '0;
    logic        load_strobe = 1'b0;
    logic        load_stop = 1'b0;
    logic        load_done;
    logic        load_error;
    logic [8:0]  load_count;
    logic        parity_err;

    int          errors = 0;
    int          checks = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_q [$];

    instruction_store #(.ADDR_W(8), .INSTR_W(32)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_fetch_req  (fetch_req),
        .i_fetch_addr (fetch_addr),
        .o_instruction(instruction),
        .o_instr_valid(instr_valid),
        .o_busy       (busy),
        .i_load_start (load_start),
        .i_load_base  (load_base),
        .i_load_byte  (load_byte),
        .i_load_strobe(load_strobe),
        .i_load_stop  (load_stop),
        .o_load_done  (load_done),
        .o_load_error (load_error),
        .o_load_count (load_count),
        .o_parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: instruction=%h, no fetch outstanding", instruction);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    $display("fetch: instruction=%h expected=%h parity_err=%b", instruction, e, parity_err);
                    if (instruction !== e || parity_err !== 1'b0) begin
                        errors++;
                        $display("FAIL fetch_data: got %h/par=%b, expected %h/par=0", instruction, parity_err, e);
                    end
                end
            end else if (instruction !== 32'h0 || parity_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_output: instruction=%h parity_err=%b, expected 0/0", instruction, parity_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [7:0] a, input logic [31:0] e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        exp_q.push_back(e);
        step();
    endtask

    task automatic drain(input string name);
        fetch_req = 1'b0;
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d fetches without instr_valid, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_load(input logic [7:0] base);
        load_start = 1'b1;
        load_base  = base;
        step();
        load_start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b, expected 1", busy);
        end
        step();
    endtask

    task automatic send_bytes(input logic [63:0] data, input int n, input logic stop_on_last);
        for (int k = 0; k < n; k++) begin
            load_strobe = 1'b1;
            load_byte   = data[8*(n-1-k) +: 8];
            load_stop   = stop_on_last && (k == n - 1);
            step();
        end
        load_strobe = 1'b0;
        load_stop   = 1'b0;
    endtask

    task automatic stop_load();
        load_stop = 1'b1;
        step();
        load_stop = 1'b0;
    endtask

    task automatic check_done(input logic exp_err, input logic [8:0] exp_cnt, input string name);
        @(negedge clk);
        checks++;
        $display("%s: load_done=%b load_error=%b busy=%b load_count=%0d", name, load_done, load_error, busy, load_count);
        if (load_done !== 1'b1 || load_error !== exp_err || busy !== 1'b0 || load_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s_done: done=%b err=%b busy=%b count=%0d, expected 1/%b/0/%0d",
                     name, load_done, load_error, busy, load_count, exp_err, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done=%b err=%b one cycle later, expected 0/0", name, load_done, load_error);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        $display("reset: instr=%h valid=%b busy=%b done=%b err=%b count=%0d par=%b",
                 instruction, instr_valid, busy, load_done, load_error, load_count, parity_err);
        if (instruction !== 32'h0 || instr_valid !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 ||
            load_error !== 1'b0 || load_count !== 9'd0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: instr=%h valid=%b busy=%b done=%b err=%b count=%0d par=%b, expected all 0",
                     instruction, instr_valid, busy, load_done, load_error, load_count, parity_err);
        end
        step();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_fetch_nop();
        fetch_one(8'h05, 32'h0000_0000);
        fetch_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL nop_fetch_latency: valid=%b busy=%b, expected 1/0", instr_valid, busy);
        end
        step();
        drain("nop_fetch");
    endtask

    task automatic test_load_basic();
        start_load(8'h10);
        send_bytes(64'h1234_5678_ABCD_EF01, 8, 1'b0);
        stop_load();
        check_done(1'b0, 9'd2, "load_basic");
        fetch_one(8'h10, 32'h1234_5678);
        fetch_req = 1'b0;
        step();
        fetch_one(8'h11, 32'hABCD_EF01);
        drain("load_basic");
        checks++;
        if (load_count !== 9'd2) begin
            errors++;
            $display("FAIL load_count_hold: load_count=%0d, expected 2", load_count);
        end
    endtask

    task automatic test_wrap();
        start_load(8'hFF);
        send_bytes(64'hDEAD_BEEF_CAFE_BABE, 8, 1'b1);
        check_done(1'b0, 9'd2, "wrap_stop_with_byte");
        fetch_one(8'hFF, 32'hDEAD_BEEF);
        fetch_one(8'h00, 32'hCAFE_BABE);
        fetch_one(8'h01, 32'h0000_0000);
        drain("wrap");
    endtask

    task automatic test_partial();
        start_load(8'h10);
        send_bytes(64'h0000_1122_3344_5566, 6, 1'b0);
        stop_load();
        check_done(1'b1, 9'd1, "partial");
        fetch_one(8'h10, 32'h1122_3344);
        fetch_one(8'h11, 32'hABCD_EF01);
        drain("partial");
    endtask

    task automatic test_priority_busy();
        load_start = 1'b1;
        load_base  = 8'h40;
        fetch_req  = 1'b1;
        fetch_addr = 8'h10;
        step();
        load_start = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_priority: valid=%b instr=%h busy=%b, expected 0/0/1", instr_valid, instruction, busy);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0 || instruction !== 32'h0) begin
                errors++;
                $display("FAIL fetch_while_busy: valid=%b instr=%h, expected 0/0", instr_valid, instruction);
            end
        end
        step();
        fetch_req = 1'b0;
        stop_load();
        check_done(1'b0, 9'd0, "empty_load");
        drain("priority");
    endtask

    task automatic test_back_to_back();
        fetch_one(8'h11, 32'hABCD_EF01);
        fetch_one(8'hFF, 32'hDEAD_BEEF);
        fetch_one(8'h10, 32'h1122_3344);
        fetch_one(8'h00, 32'hCAFE_BABE);
        drain("back_to_back");
    endtask

    task automatic test_reset_midload();
        start_load(8'h20);
        send_bytes(64'h0000_0001_0203_0405, 5, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        $display("reset_midload: busy=%b done=%b count=%0d", busy, load_done, load_count);
        if (busy !== 1'b0 || load_done !== 1'b0 || load_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_midload: busy=%b done=%b count=%0d, expected 0/0/0", busy, load_done, load_count);
        end
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midload_done: load_done=%b, expected 0", load_done);
        end
        step();
        fetch_one(8'h20, 32'h0102_0304);
        fetch_one(8'h21, 32'h0000_0000);
        drain("reset_midload");
    endtask

    initial begin
        test_reset();
        test_fetch_nop();
        test_load_basic();
        test_wrap();
        test_partial();
        test_priority_busy();
        test_back_to_back();
        test_reset_midload();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
